pkt_link_tx_sched: RTL



---
 rtl/pkt_link_pkg.sv | 47 ++++
 rtl/pkt_link_tx_sched_if.sv | 40 ++++
 rtl/pkt_link_tx_sched_arb.sv | 36 +++
 rtl/pkt_link_tx_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pkt_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkt_link_pkg
// Description : Shared definitions for the packet link. Frame delimiters,
//               header length, TX scheduler state encoding and the frame
//               checksum helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pkt_link_pkg;

    localparam logic [7:0] START_BYTE = 8'hAA;
    localparam logic [7:0] END_BYTE   = 8'h55;
    localparam int         HDR_LEN    = 3;     // START, type, length

    // Widest payload the checksum helper accepts (bytes).
    localparam int         PKT_MAX_PD = 64;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_TYPE  = 3'd2,
        S_LEN   = 3'd3,
        S_PD    = 3'd4,
        S_CHK   = 3'd5,
        S_END   = 3'd6,
        S_GAP   = 3'd7
    } pkt_tx_state_t;

    // XOR of type, length and the first 'len' payload bytes. The payload is
    // LSB-aligned; byte order does not matter for an XOR.
    function automatic logic [7:0] pkt_xor_chk(
        input logic [7:0]              typ,
        input logic [7:0]              len,
        input logic [8*PKT_MAX_PD-1:0] pd
    );
        logic [7:0] chk;
        chk = typ ^ len;
        for (int i = 0; i < PKT_MAX_PD; i++) begin
            if (i < int'(len)) begin
                chk = chk ^ pd[8*i +: 8];
            end
        end
        return chk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_link_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : pkt_link_tx_sched_if
// Description : Requester and UART-TX byte channel bundle of the transmit
//               scheduler.
//               i_req/i_type/i_pd : per-requester request, type and payload
//               o_gnt             : one-hot grant pulse
//               o_data/o_valid    : TX byte and qualifier
//               i_ready           : TX accepts the byte
//               o_busy/o_src      : frame in progress / current requester
//               modport master = scheduler side, slave = producers + UART.
// Revision    : 1.0 - initial release
// ============================================================================
interface pkt_link_tx_sched_if
    import pkt_link_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int PD_LEN = 2
);
    logic [N_REQ-1:0]          i_req;
    logic [8*N_REQ-1:0]        i_type;
    logic [8*PD_LEN*N_REQ-1:0] i_pd;
    logic [N_REQ-1:0]          o_gnt;
    logic [7:0]                o_data;
    logic                      o_valid;
    logic                      i_ready;
    logic                      o_busy;
    logic [$clog2(N_REQ)-1:0]  o_src;

    modport master (
        input  i_req, i_type, i_pd, i_ready,
        output o_gnt, o_data, o_valid, o_busy, o_src
    );

    modport slave (
        output i_req, i_type, i_pd, i_ready,
        input  o_gnt, o_data, o_valid, o_busy, o_src
    );
endinterface
`default_nettype wire

// File: rtl/pkt_link_tx_sched_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Scans req starting at ptr,
//               wrapping modulo N, and returns the first set bit.
//               req/ptr in; one-hot gnt, its index and any-request out.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] w_pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        w_pos = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = IW'((int'(ptr) + i) % N);
            if (!any && req[w_pos]) begin
                any        = 1'b1;
                gnt[w_pos] = 1'b1;
                idx        = w_pos;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/pkt_link_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : pkt_link_tx_sched
// Description : Round-robin transmit scheduler. Grants one of N_REQ
//               requesters, captures its type/payload and sends the frame
//               START, type, length, payload (MSB byte first), checksum, END
//               over a valid/ready byte channel, then idles GAP_CYC cycles.
//               clk, rst_n (async, active-low), bus (interface, master).
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_link_tx_sched
    import pkt_link_pkg::*;
#(
    parameter int PD_LEN  = 2,
    parameter int N_REQ   = 4,
    parameter int GAP_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    pkt_link_tx_sched_if.master bus
);
    localparam int         IDX_W    = $clog2(N_REQ);
    localparam int         PD_W     = 8 * PD_LEN;
    localparam int         CNT_W    = (PD_LEN > 1) ? $clog2(PD_LEN) : 1;
    localparam int         GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PD_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [7:0] LEN_BYTE = 8'(PD_LEN);

    pkt_tx_state_t     r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [7:0]        r_type;
    logic [PD_W-1:0]   r_pd;       // shifted left as payload bytes go out
    logic [7:0]        r_chk;
    logic [CNT_W-1:0]  r_cnt;
    logic [GAP_W-1:0]  r_gap;
    logic [N_REQ-1:0]  r_gnt;
    logic [7:0]        r_data;
    logic              r_valid;
    logic              r_busy;
    logic [IDX_W-1:0]  r_src;

    logic [N_REQ-1:0]          w_gnt;
    logic [IDX_W-1:0]          w_idx;
    logic                      w_any;
    logic [7:0]                w_sel_type;
    logic [PD_W-1:0]           w_sel_pd;
    logic [8*PKT_MAX_PD-1:0]   w_pd_pad;
    logic [7:0]                w_chk;
    logic                      w_xfer;

    rr_arbiter #(.N(N_REQ), .IW(IDX_W)) u_arb (
        .req (bus.i_req),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_idx),
        .any (w_any)
    );

    // Mux the winner's fields with the one-hot grant.
    always_comb begin
        w_sel_type = '0;
        w_sel_pd   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt[k]) begin
                w_sel_type = bus.i_type[8*k +: 8];
                w_sel_pd   = bus.i_pd[PD_W*k +: PD_W];
            end
        end
    end

    always_comb begin
        w_pd_pad             = '0;
        w_pd_pad[PD_W-1:0]   = r_pd;
    end

    assign w_chk  = pkt_xor_chk(r_type, LEN_BYTE, w_pd_pad);
    assign w_xfer = r_valid && bus.i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_type  <= '0;
            r_pd    <= '0;
            r_chk   <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_gnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_src   <= '0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_type  <= w_sel_type;
                        r_pd    <= w_sel_pd;
                        r_gnt   <= w_gnt;
                        r_src   <= w_idx;
                        r_ptr   <= (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + IDX_W'(1);
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                        r_data  <= START_BYTE;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_xfer) begin
                        r_data  <= r_type;
                        r_state <= S_TYPE;
                    end
                end
                S_TYPE: begin
                    // Payload is still unshifted here, so the checksum is
                    // taken from the captured fields.
                    r_chk <= w_chk;
                    if (w_xfer) begin
                        r_data  <= LEN_BYTE;
                        r_state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_xfer) begin
                        r_data  <= r_pd[PD_W-1 -: 8];
                        r_pd    <= r_pd << 8;
                        r_cnt   <= '0;
                        r_state <= S_PD;
                    end
                end
                S_PD: begin
                    if (w_xfer) begin
                        if (r_cnt == CNT_LAST) begin
                            r_data  <= r_chk;
                            r_state <= S_CHK;
                        end else begin
                            r_data <= r_pd[PD_W-1 -: 8];
                            r_pd   <= r_pd << 8;
                            r_cnt  <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_CHK: begin
                    if (w_xfer) begin
                        r_data  <= END_BYTE;
                        r_state <= S_END;
                    end
                end
                S_END: begin
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_gap   <= '0;
                        r_state <= (GAP_CYC > 0) ? S_GAP : S_IDLE;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_gnt   = r_gnt;
    assign bus.o_data  = r_data;
    assign bus.o_valid = r_valid;
    assign bus.o_busy  = r_busy;
    assign bus.o_src   = r_src;

endmodule
`default_nettype wire
